// File: rtl/rsa_operand_shiftreg.sv
// rsa_operand_shiftreg: WIDTH-bit Montgomery operand register with N-source parallel load and LSB-first serial scan
// Ports:
//    clk        rising-edge clock
//    rstb       asynchronous active-low reset
//    ena        cycle enable; 0 freezes all state and handshake outputs
//    clear      synchronous clear, active-low, qualified by ena (highest priority)
//    load       parallel load from src_data[src_sel], qualified by ena
//    src_sel    load source index; values >= NSRC load zero
//    src_data   packed sources, source k = src_data[k*WIDTH +: WIDTH]
//    scan_start begin a WIDTH-bit LSB-first scan from IDLE
//    R_o        register contents
//    bit_o      scanned bit, qualified by bit_valid
//    bit_valid  bit_o is valid
//    bit_idx    index of bit_o within the pre-scan operand
//    busy       scan in progress
//    done       one enabled-cycle pulse after the last bit
// Build option: define ROTATE_EN to rotate during the scan (operand restored
// after a full scan); otherwise the scan shifts in zeros.
module rsa_operand_shiftreg #(
   parameter int WIDTH = 8,
   parameter int NSRC  = 2,
   parameter int SEL_W = $clog2(NSRC)
) (
   input  logic                     clk,
   input  logic                     rstb,
   input  logic                     ena,
   input  logic                     clear,
   input  logic                     load,
   input  logic [SEL_W-1:0]         src_sel,
   input  logic [NSRC*WIDTH-1:0]    src_data,
   input  logic                     scan_start,
   output logic [WIDTH-1:0]         R_o,
   output logic                     bit_o,
   output logic                     bit_valid,
   output logic [$clog2(WIDTH)-1:0] bit_idx,
   output logic                     busy,
   output logic                     done
);
   localparam int IW = $clog2(WIDTH);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SCAN = 1'b1;
   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_reg;
   logic             r_bit;
   logic             r_valid;
   logic [IW-1:0]    r_idx;
   logic             r_done;
   logic [WIDTH-1:0] w_src;
   logic [WIDTH-1:0] w_shift;
   logic             w_last;
   // out-of-range selects fall through to zero
   always_comb begin
      w_src = '0;
      for (int k = 0; k < NSRC; k++)
         if (src_sel == SEL_W'(k)) w_src = src_data[k*WIDTH +: WIDTH];
   end
`ifdef ROTATE_EN
   assign w_shift = {r_reg[0], r_reg[WIDTH-1:1]};
`else
   assign w_shift = {1'b0, r_reg[WIDTH-1:1]};
`endif
   assign w_last = r_idx == IW'(WIDTH-1);
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_state <= IDLE;
         r_reg   <= '0;
         r_bit   <= 1'b0;
         r_valid <= 1'b0;
         r_idx   <= '0;
         r_done  <= 1'b0;
      end else if (ena) begin
         if (!clear || load) begin
            r_state <= IDLE;
            r_reg   <= clear ? w_src : '0;
            r_bit   <= 1'b0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_done  <= 1'b0;
         end else if (r_state == SCAN) begin
            // last bit already presented: leave SCAN and pulse done
            if (w_last) begin
               r_state <= IDLE;
               r_valid <= 1'b0;
               r_done  <= 1'b1;
            end else begin
               r_bit   <= r_reg[0];
               r_idx   <= r_idx + 1'b1;
               r_reg   <= w_shift;
            end
         end else begin
            r_done <= 1'b0;
            r_valid <= scan_start;
            if (scan_start) begin
               r_state <= SCAN;
               r_bit   <= r_reg[0];
               r_idx   <= '0;
               r_reg   <= w_shift;
            end
         end
      end
   end
   assign R_o       = r_reg;
   assign bit_o     = r_bit;
   assign bit_valid = r_valid;
   assign bit_idx   = r_idx;
   assign busy      = r_state == SCAN;
   assign done      = r_done;
endmodule

// File: tb/tb_rsa_operand_shiftreg.sv
// tb_rsa_operand_shiftreg: randomized and directed checks of rsa_operand_shiftreg against an operand/bit-count model
module tb_rsa_operand_shiftreg;
   localparam int W = 8;
   localparam int N = 3;
   logic clk = 1'b0, rstb = 1'b0, ena = 1'b0, clear = 1'b1, load = 1'b0, scan_start = 1'b0;
   logic [1:0] src_sel = '0;
   logic [N*W-1:0] src_data = '0;
   logic [W-1:0] R_o;
   logic bit_o, bit_valid, busy, done;
   logic [2:0] bit_idx;
   int total = 0, passed = 0;
   rsa_operand_shiftreg #(.WIDTH(W), .NSRC(N)) dut (
      .clk(clk), .rstb(rstb), .ena(ena), .clear(clear), .load(load),
      .src_sel(src_sel), .src_data(src_data), .scan_start(scan_start),
      .R_o(R_o), .bit_o(bit_o), .bit_valid(bit_valid), .bit_idx(bit_idx),
      .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask
   // model: operand captured at scan start plus count of bits presented
   logic [W-1:0] m_reg = '0, m_orig = '0;
   int m_k = 0, m_idx = 0;
   bit m_act = 0, m_valid = 0, m_bit = 0, m_done = 0;
   function automatic logic [W-1:0] after(input logic [W-1:0] o, input int k);
      logic [2*W-1:0] t;
      t = {o, o} >> k;
`ifdef ROTATE_EN
      return t[W-1:0];
`else
      return o >> k;
`endif
   endfunction
   always @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         m_reg <= '0; m_act <= 0; m_valid <= 0; m_idx <= 0; m_done <= 0; m_k <= 0;
      end else if (ena) begin
         if (!clear || load) begin
            m_reg <= (clear && int'(src_sel) < N) ? src_data[int'(src_sel)*W +: W] : '0;
            m_act <= 0; m_valid <= 0; m_idx <= 0; m_done <= 0;
         end else if (m_act) begin
            if (m_k == W) begin
               m_act <= 0; m_valid <= 0; m_done <= 1;
            end else begin
               m_bit <= m_orig[m_k]; m_idx <= m_k; m_k <= m_k + 1; m_reg <= after(m_orig, m_k + 1);
            end
         end else begin
            m_done <= 0;
            m_valid <= scan_start;
            if (scan_start) begin
               m_orig <= m_reg; m_k <= 1; m_bit <= m_reg[0]; m_idx <= 0; m_act <= 1;
               m_reg <= after(m_reg, 1);
            end
         end
      end
   end
   always @(negedge clk) if (rstb) begin
      chk("R_o", R_o, m_reg);
      chk("busy", busy, m_act);
      chk("bit_valid", bit_valid, m_valid);
      chk("bit_idx", bit_idx, m_idx);
      chk("done", done, m_done);
      chk("done_valid_excl", done & bit_valid, 0);
      if (m_valid) chk("bit_o", bit_o, m_bit);
   end
   task automatic cyc(input logic e, input logic c, input logic l, input logic [1:0] s, input logic st);
      ena = e; clear = c; load = l; src_sel = s; scan_start = st;
      @(negedge clk);
   endtask
   task automatic collect(input int n, input bit tog, output logic [W-1:0] seq, output int nv, output int nd);
      logic pd;
      pd = 0; seq = '0; nv = 0; nd = 0;
      for (int i = 0; i < n; i++) begin
         if (bit_valid) begin seq[bit_idx] = bit_o; nv++; end
         if (done && !pd) nd++;
         pd = done;
         cyc(tog ? i[0] : 1'b1, 1, 0, 0, 0);
      end
   endtask
   logic [W-1:0] seq, fin;
   int nv, nd, guard;
   initial begin
`ifdef ROTATE_EN
      fin = 8'hA5;
`else
      fin = 8'h00;
`endif
      src_data = {8'h3C, 8'hA5, 8'h5A};
      repeat (2) @(negedge clk);
      chk("rst_R_o", R_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", bit_valid, 0);
      chk("rst_done", done, 0);
      rstb = 1'b1;
      cyc(1, 1, 1, 1, 0);
      chk("load_a5", R_o, 8'hA5);
      cyc(1, 1, 0, 0, 1);
      collect(12, 0, seq, nv, nd);
      chk("scan_seq", seq, 8'hA5);
      chk("scan_nvalid", nv, 8);
      chk("scan_ndone", nd, 1);
      chk("scan_final", R_o, fin);
      cyc(1, 1, 1, 1, 0);
      cyc(1, 1, 0, 0, 1);
      collect(30, 1, seq, nv, nd);
      chk("stretch_seq", seq, 8'hA5);
      chk("stretch_ndone", nd, 1);
      chk("stretch_final", R_o, fin);
      cyc(1, 1, 1, 1, 0);
      cyc(1, 0, 1, 1, 1);
      chk("prio_clear_R", R_o, 0);
      chk("prio_clear_busy", busy, 0);
      chk("prio_clear_valid", bit_valid, 0);
      cyc(1, 1, 1, 1, 0);
      cyc(1, 1, 0, 0, 1);
      guard = 0;
      while (bit_idx != 3 && guard < 10) begin cyc(1, 1, 0, 0, 0); guard++; end
      chk("abort_reach_idx3", bit_idx, 3);
      cyc(1, 1, 1, 2, 0);
      chk("abort_R", R_o, 8'h3C);
      chk("abort_busy", busy, 0);
      collect(6, 0, seq, nv, nd);
      chk("abort_no_done", nd, 0);
      cyc(1, 1, 1, 1, 0);
      cyc(1, 1, 1, 3, 0);
      chk("sel3_zero", R_o, 0);
      cyc(1, 1, 1, 2, 0);
      chk("sel2", R_o, 8'h3C);
      cyc(1, 1, 1, 0, 0);
      chk("sel0", R_o, 8'h5A);
      nd = 0;
      for (int i = 0; i < 30; i++) begin
         cyc(1, 1, 0, 0, 1);
         if (done) nd++;
      end
      chk("b2b_done_pulses", nd, 3);
      for (int i = 0; i < 500; i++) begin
         src_data = {8'($urandom), 8'($urandom), 8'($urandom)};
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 40) != 0, $urandom_range(0, 12) == 0,
             2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
      end
      cyc(1, 1, 1, 1, 0);
      cyc(1, 1, 0, 0, 1);
      repeat (3) cyc(1, 1, 0, 0, 0);
      #2 rstb = 1'b0;
      #1;
      chk("async_R", R_o, 0);
      chk("async_busy", busy, 0);
      chk("async_valid", bit_valid, 0);
      chk("async_idx", bit_idx, 0);
      chk("async_bit", bit_o, 0);
      chk("async_done", done, 0);
      @(negedge clk);
      rstb = 1'b1;
      cyc(1, 1, 0, 0, 0);
      chk("post_rst_idle", busy, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
